// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-rate divider, sx/sy scan counters, pipelined syncs/enable and strobes.
// Define VTG_FRAME_COUNT_EN to build the 16-bit frame counter; otherwise frame_count is tied to 0.
module video_timing_gen #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter bit H_SYNC_POL     = 1'b0,
  parameter bit V_SYNC_POL     = 1'b0,
  parameter int PIX_DIV        = 1,
  parameter int PIPE_DELAY     = 0,
  localparam int H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_WHOLE_LINE  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int H_ADDR_WIDTH  = $clog2(H_WHOLE_LINE),
  localparam int V_ADDR_WIDTH  = $clog2(V_WHOLE_LINE)
) (
  input  logic                    vga_pix_clk,
  input  logic                    rst,
  output logic [H_ADDR_WIDTH-1:0] sx,
  output logic [V_ADDR_WIDTH-1:0] sy,
  output logic                    pix_tick,
  output logic                    H_SYNC,
  output logic                    V_SYNC,
  output logic                    display_enabled,
  output logic                    frame_stb,
  output logic                    line_stb,
  output logic [15:0]             frame_count
);

  localparam logic [H_ADDR_WIDTH-1:0] H_LAST       = H_ADDR_WIDTH'(H_WHOLE_LINE - 1);
  localparam logic [H_ADDR_WIDTH-1:0] H_VIS        = H_ADDR_WIDTH'(H_VISIBLE_AREA);
  localparam logic [H_ADDR_WIDTH-1:0] H_SYNC_FIRST = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [H_ADDR_WIDTH-1:0] H_SYNC_LAST  =
    H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_LAST       = V_ADDR_WIDTH'(V_WHOLE_LINE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_VIS        = V_ADDR_WIDTH'(V_VISIBLE_AREA);
  localparam logic [V_ADDR_WIDTH-1:0] V_SYNC_FIRST = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [V_ADDR_WIDTH-1:0] V_SYNC_LAST  =
    V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE - 1);
  localparam logic [3:0]              DIV_LAST     = 4'(PIX_DIV - 1);

  logic [3:0] div;
  logic [2:0] act_now;
  logic [2:0] act_out;
  logic [2:0] act_gated;

  // Strobes are gated by rst so a reset landing mid-frame never leaks a partial tick.
  assign pix_tick  = (div == DIV_LAST) && !rst;
  assign line_stb  = pix_tick && (sx == '0);
  assign frame_stb = line_stb && (sy == '0);

  always_ff @(posedge vga_pix_clk) begin
    if (rst || pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (pix_tick) begin
      if (sx == H_LAST) begin
        sx <= '0;
        sy <= (sy == V_LAST) ? '0 : sy + 1'b1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  // Active-high flags {enable, vsync, hsync}; polarity is applied only after the delay line.
  assign act_now[0] = (sx >= H_SYNC_FIRST) && (sx <= H_SYNC_LAST);
  assign act_now[1] = (sy >= V_SYNC_FIRST) && (sy <= V_SYNC_LAST);
  assign act_now[2] = (sx < H_VIS) && (sy < V_VIS);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign act_out = act_now;
    end else begin : g_delay
      logic [2:0] stage [PIPE_DELAY];

      always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            stage[i] <= '0;
          end
        end else if (pix_tick) begin
          stage[0] <= act_now;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign act_out = stage[PIPE_DELAY-1];
    end
  endgenerate

  assign act_gated       = act_out & {3{~rst}};
  assign H_SYNC          = act_gated[0] ? H_SYNC_POL : ~H_SYNC_POL;
  assign V_SYNC          = act_gated[1] ? V_SYNC_POL : ~V_SYNC_POL;
  assign display_enabled = act_gated[2];

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_stb) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_count = frame_cnt;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: dut0 runs default 640x480 timing, dut1 a tiny 16x11 raster with PIX_DIV=4,
// PIPE_DELAY=2 and active-high syncs so whole frames fit in a short run.
module tb_video_timing_gen;

  logic       clk;
  logic       rst0;
  logic       rst1;
  logic [9:0] sx0;
  logic [9:0] sy0;
  logic       pix_tick0, h_sync0, v_sync0, de0, frame_stb0, line_stb0;
  logic [15:0] fc0;
  logic [3:0] sx1;
  logic [3:0] sy1;
  logic       pix_tick1, h_sync1, v_sync1, de1, frame_stb1, line_stb1;
  logic [15:0] fc1;

  int checks = 0;
  int errors = 0;

  video_timing_gen dut0 (
    .vga_pix_clk(clk), .rst(rst0), .sx(sx0), .sy(sy0), .pix_tick(pix_tick0),
    .H_SYNC(h_sync0), .V_SYNC(v_sync0), .display_enabled(de0),
    .frame_stb(frame_stb0), .line_stb(line_stb0), .frame_count(fc0)
  );

  video_timing_gen #(
    .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
    .V_VISIBLE_AREA(6), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(4), .PIPE_DELAY(2)
  ) dut1 (
    .vga_pix_clk(clk), .rst(rst1), .sx(sx1), .sy(sy1), .pix_tick(pix_tick1),
    .H_SYNC(h_sync1), .V_SYNC(v_sync1), .display_enabled(de1),
    .frame_stb(frame_stb1), .line_stb(line_stb1), .frame_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic apply_stimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  int hs_low, hs_first, hs_last, en_cnt, lstb_cnt, fstb_cnt, vs_bad, wait_cnt;
  int vs_high, vs_first_sx, vs_first_sy, vs_last_sx, vs_last_sy, tick_cnt;

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    apply_stimulus(3);

    // Reset state of both instances.
    check_output("rst0_sx", 32'(sx0), 0);
    check_output("rst0_sy", 32'(sy0), 0);
    check_output("rst0_pix_tick", 32'(pix_tick0), 0);
    check_output("rst0_line_stb", 32'(line_stb0), 0);
    check_output("rst0_frame_stb", 32'(frame_stb0), 0);
    check_output("rst0_h_sync", 32'(h_sync0), 1);
    check_output("rst0_v_sync", 32'(v_sync0), 1);
    check_output("rst0_de", 32'(de0), 0);
    check_output("rst1_h_sync", 32'(h_sync1), 0);
    check_output("rst1_v_sync", 32'(v_sync1), 0);
    check_output("rst1_de", 32'(de1), 0);
    check_output("rst1_pix_tick", 32'(pix_tick1), 0);
    check_output("rst0_frame_count", 32'(fc0), 0);

    // dut0: release and scan line 0 (PIX_DIV=1 ticks in the very first cycle).
    rst0 = 1'b0;
    #1;
    check_output("d0_first_frame_stb", 32'(frame_stb0), 1);
    check_output("d0_first_pix_tick", 32'(pix_tick0), 1);
    hs_low = 0; hs_first = -1; hs_last = -1; en_cnt = 0; lstb_cnt = 0; fstb_cnt = 0; vs_bad = 0;
    for (int c = 0; c < 800; c++) begin
      if (h_sync0 == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = 32'(sx0);
        hs_last = 32'(sx0);
      end
      if (de0) en_cnt++;
      if (c > 0 && line_stb0) lstb_cnt++;
      if (c > 0 && frame_stb0) fstb_cnt++;
      if (v_sync0 != 1'b1) vs_bad++;
      @(negedge clk);
    end
    check_output("d0_hsync_low_count", hs_low, 96);
    check_output("d0_hsync_first_sx", hs_first, 656);
    check_output("d0_hsync_last_sx", hs_last, 751);
    check_output("d0_enable_count", en_cnt, 640);
    check_output("d0_line_stb_inside_line", lstb_cnt, 0);
    check_output("d0_frame_stb_inside_line", fstb_cnt, 0);
    check_output("d0_vsync_inactive", vs_bad, 0);
    check_output("d0_line_stb_period", 32'(line_stb0), 1);
    check_output("d0_line1_sx", 32'(sx0), 0);
    check_output("d0_line1_sy", 32'(sy0), 1);
    check_output("d0_line1_no_frame_stb", 32'(frame_stb0), 0);

    // dut0: reset mid-line at sx=300 on line 1.
    wait_cnt = 0;
    while (sx0 != 10'd300 && wait_cnt < 1000) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_output("d0_reach_sx300", 32'(wait_cnt < 1000), 1);
    rst0 = 1'b1;
    #1;
    check_output("d0_rst_gates_tick", 32'(pix_tick0), 0);
    @(negedge clk);
    check_output("d0_midrst_sx", 32'(sx0), 0);
    check_output("d0_midrst_sy", 32'(sy0), 0);
    check_output("d0_midrst_line_stb", 32'(line_stb0), 0);
    check_output("d0_midrst_de", 32'(de0), 0);
    check_output("d0_midrst_h_sync", 32'(h_sync0), 1);
    rst0 = 1'b0;
    #1;
    check_output("d0_release_frame_stb", 32'(frame_stb0), 1);

    // dut1: release and run one full frame (16*11 pixels * 4 clocks = 704 clocks).
    rst1 = 1'b0;
    #1;
    vs_high = 0; vs_first_sx = -1; vs_first_sy = -1; vs_last_sx = -1; vs_last_sy = -1;
    tick_cnt = 0; lstb_cnt = 0; fstb_cnt = 0;
    for (int r = 0; r <= 707; r++) begin
      if (r == 2) check_output("d1_no_early_tick", 32'(pix_tick1), 0);
      if (r == 3) begin
        check_output("d1_first_tick", 32'(pix_tick1), 1);
        check_output("d1_first_frame_stb", 32'(frame_stb1), 1);
      end
      if (r == 4) check_output("d1_sx_r4", 32'(sx1), 1);
      if (r == 7) begin
        check_output("d1_sx_r7", 32'(sx1), 1);
        check_output("d1_de_r7", 32'(de1), 0);
      end
      if (r == 8) begin
        check_output("d1_sx_r8", 32'(sx1), 2);
        check_output("d1_de_rise", 32'(de1), 1);
      end
      if (r == 39) check_output("d1_de_r39", 32'(de1), 1);
      if (r == 40) check_output("d1_de_fall", 32'(de1), 0);
      if (r == 47) check_output("d1_hs_r47", 32'(h_sync1), 0);
      if (r == 48) check_output("d1_hs_r48", 32'(h_sync1), 1);
      if (r == 59) check_output("d1_hs_r59", 32'(h_sync1), 1);
      if (r == 60) check_output("d1_hs_r60", 32'(h_sync1), 0);
      if (r == 707) begin
        check_output("d1_frame_period", 32'(frame_stb1), 1);
        check_output("d1_wrap_sx", 32'(sx1), 0);
        check_output("d1_wrap_sy", 32'(sy1), 0);
      end
      if (r < 707) begin
        if (pix_tick1) tick_cnt++;
        if (line_stb1) lstb_cnt++;
        if (r > 3 && frame_stb1) fstb_cnt++;
        if (v_sync1) begin
          vs_high++;
          if (vs_first_sx < 0) begin
            vs_first_sx = 32'(sx1);
            vs_first_sy = 32'(sy1);
          end
          vs_last_sx = 32'(sx1);
          vs_last_sy = 32'(sy1);
        end
      end
      @(negedge clk);
    end
    check_output("d1_tick_count", tick_cnt, 176);
    check_output("d1_line_stb_count", lstb_cnt, 11);
    check_output("d1_extra_frame_stb", fstb_cnt, 0);
    check_output("d1_vs_high_cycles", vs_high, 128);
    check_output("d1_vs_first_sy", vs_first_sy, 7);
    check_output("d1_vs_first_sx", vs_first_sx, 2);
    check_output("d1_vs_last_sy", vs_last_sy, 9);
    check_output("d1_vs_last_sx", vs_last_sx, 1);

    // dut1: reset mid-frame at sx=5, sy=3.
    wait_cnt = 0;
    while (!(sx1 == 4'd5 && sy1 == 4'd3) && wait_cnt < 2000) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_output("d1_reach_point", 32'(wait_cnt < 2000), 1);
`ifdef VTG_FRAME_COUNT_EN
    check_output("d1_frame_count_two", 32'(fc1), 2);
`endif
    rst1 = 1'b1;
    #1;
    check_output("d1_rst_gates_tick", 32'(pix_tick1), 0);
    @(negedge clk);
    check_output("d1_midrst_sx", 32'(sx1), 0);
    check_output("d1_midrst_sy", 32'(sy1), 0);
    check_output("d1_midrst_frame_stb", 32'(frame_stb1), 0);
    check_output("d1_midrst_line_stb", 32'(line_stb1), 0);
    check_output("d1_midrst_v_sync", 32'(v_sync1), 0);
    check_output("d1_midrst_de", 32'(de1), 0);
    rst1 = 1'b0;
    #1;
    check_output("d1_release_no_stb", 32'(frame_stb1), 0);
`ifdef VTG_FRAME_COUNT_EN
    check_output("d1_frame_count_reset", 32'(fc1), 0);
    force dut1.frame_cnt = 16'hFFFF;
    #1;
    release dut1.frame_cnt;
`endif
    apply_stimulus(3);
    check_output("d1_release_frame_stb", 32'(frame_stb1), 1);
    check_output("d1_release_pix_tick", 32'(pix_tick1), 1);
    apply_stimulus(1);
    check_output("d1_frame_count_after", 32'(fc1), 0);
    check_output("d1_release_sx", 32'(sx1), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
